// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch history table of 2-bit saturating counters with
// branch / mispredict event counters. Lookup in IF is combinational, update in X.
module branch_predictor #(
    parameter  int LINES = 32,
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] guess_pc,
    input  logic        guess_is_br,
    output logic        guess_taken,
    input  logic [31:0] check_pc,
    input  logic        check_valid,
    input  logic        check_taken,
    input  logic        check_pred,
    input  logic        stall,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [1:0]       ctr_q [LINES];
    logic [31:0]      br_count_q;
    logic [31:0]      mispred_count_q;

    logic [IDX_W-1:0] g_idx_s;
    logic [TAG_W-1:0] g_tag_s;
    logic [IDX_W-1:0] c_idx_s;
    logic [TAG_W-1:0] c_tag_s;
    logic             c_hit_s;
    logic             upd_en_s;
    logic [1:0]       upd_ctr_s;
    logic             e_valid_s;
    logic [TAG_W-1:0] e_tag_s;
    logic [1:0]       e_ctr_s;
    logic             unused_pc_bits_s;

    // Saturating step of a 2-bit counter toward taken (up) or not-taken (down).
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    assign g_idx_s          = guess_pc[2+IDX_W-1:2];
    assign g_tag_s          = guess_pc[31:2+IDX_W];
    assign c_idx_s          = check_pc[2+IDX_W-1:2];
    assign c_tag_s          = check_pc[31:2+IDX_W];
    assign unused_pc_bits_s = ^{guess_pc[1:0], check_pc[1:0]};
    assign upd_en_s         = check_valid && !stall;

    // New counter value for the resolving branch: step on hit, allocate weak on miss.
    always_comb begin
        c_hit_s   = valid_q[c_idx_s] && (tag_q[c_idx_s] == c_tag_s);
        upd_ctr_s = 2'b01;
        if (c_hit_s) begin
            upd_ctr_s = ctr_step(ctr_q[c_idx_s], check_taken);
        end else begin
            upd_ctr_s = check_taken ? 2'b10 : 2'b01;
        end
    end

    // Lookup entry, bypassing the entry being written this cycle on an index match.
    always_comb begin
        e_valid_s = valid_q[g_idx_s];
        e_tag_s   = tag_q[g_idx_s];
        e_ctr_s   = ctr_q[g_idx_s];
        if (upd_en_s && (g_idx_s == c_idx_s)) begin
            e_valid_s = 1'b1;
            e_tag_s   = c_tag_s;
            e_ctr_s   = upd_ctr_s;
        end else begin
            e_valid_s = valid_q[g_idx_s];
        end
    end

    assign guess_taken   = guess_is_br && e_valid_s && (e_tag_s == g_tag_s) && e_ctr_s[1];
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

    // Valid bits and event counters; reset clears them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q         <= '0;
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else if (upd_en_s) begin
            valid_q[c_idx_s] <= 1'b1;
            br_count_q       <= br_count_q + 32'd1;
            if (check_pred != check_taken) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    // Tag and counter payload; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (upd_en_s && rst) begin
            tag_q[c_idx_s] <= c_tag_s;
            ctr_q[c_idx_s] <= upd_ctr_s;
        end
    end

endmodule
